// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - Fetch stage PC register plus IF/ID pipeline register
//
// Holds the fetch PC and the IF/ID pipeline register. The hazard unit controls
// them through PCWrite, IFIDWrite and Flush. Branches taken in ID redirect the
// PC through Branch and BranchTarget.
//
// Optional feature: define IF_ID_PERF_COUNT_EN to add the saturating
// StallCount and FlushCount performance counters. Without that macro the
// counters and their ports do not exist.
//
// Ports:
//   Clk             in   rising-edge clock
//   Reset           in   synchronous active-high reset
//   PCWrite         in   1 = PC may advance, 0 = stall (PC and IF/ID hold)
//   IFIDWrite       in   1 = IF/ID may load, 0 = IF/ID holds
//   Flush           in   1 = load a bubble into IF/ID instead of the fetched word
//   Branch          in   1 = redirect PC to BranchTarget
//   BranchTarget    in   [31:0] redirect address
//   InstrData       in   [31:0] instruction memory read data at PC
//   PC              out  [31:0] current fetch address
//   Instruction     out  [31:0] IF-stage instruction (InstrData passed through)
//   InstructionIFID out  [31:0] registered IF/ID instruction
//   PCPlus4IFID     out  [31:0] registered PC+4 of the IF/ID instruction
//   ValidIFID       out  1 = IF/ID holds a real instruction, 0 = bubble
//   StallCount      out  [15:0] edges with PCWrite=0 (IF_ID_PERF_COUNT_EN only)
//   FlushCount      out  [15:0] edges with PCWrite=1 and Flush=1 (IF_ID_PERF_COUNT_EN only)

module if_id_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        Flush,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] InstrData,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic [31:0] InstructionIFID,
    output logic [31:0] PCPlus4IFID,
    output logic        ValidIFID
`ifdef IF_ID_PERF_COUNT_EN
    ,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
`endif
);

    // The adder is 32 bits wide, so 0xFFFFFFFC + 4 wraps to 0.
    logic [31:0] pc_plus4;

    assign pc_plus4    = PC + 32'd4;
    assign Instruction = InstrData;

    // PCWrite=0 freezes both PC and IF/ID. Branch and Flush are ignored in that
    // cycle because the branch operands are stale during a load-use stall.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC              <= 32'h0000_0000;
            InstructionIFID <= 32'h0000_0000;
            PCPlus4IFID     <= 32'h0000_0000;
            ValidIFID       <= 1'b0;
        end else if (PCWrite) begin
            PC <= Branch ? BranchTarget : pc_plus4;
            // When IFIDWrite=0 the PC still moves, and the fetched word is dropped.
            if (IFIDWrite) begin
                if (Flush) begin
                    // A bubble is sll $0,$0,0 with no return address and not valid.
                    InstructionIFID <= 32'h0000_0000;
                    PCPlus4IFID     <= 32'h0000_0000;
                    ValidIFID       <= 1'b0;
                end else begin
                    InstructionIFID <= InstrData;
                    PCPlus4IFID     <= pc_plus4;
                    ValidIFID       <= 1'b1;
                end
            end
        end
    end

`ifdef IF_ID_PERF_COUNT_EN
    // Both counters stop at 0xFFFF instead of rolling over.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCount <= 16'h0000;
            FlushCount <= 16'h0000;
        end else begin
            if (!PCWrite && StallCount != 16'hFFFF) begin
                StallCount <= StallCount + 16'd1;
            end
            if (PCWrite && Flush && FlushCount != 16'hFFFF) begin
                FlushCount <= FlushCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port Clk, input, 1, the single rising-edge clock for all state.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset sampled on the Clk rising edge.
REQ-003 SHALL have port PCWrite, input, 1; 1 = PC may advance, 0 = stall, from the hazard unit.
REQ-004 SHALL have port IFIDWrite, input, 1; 1 = IF/ID register may load, 0 = hold, from the hazard unit.
REQ-005 SHALL have port Flush, input, 1; 1 = squash the instruction entering IF/ID, from the hazard unit.
REQ-006 SHALL have port Branch, input, 1; 1 = taken branch resolved in ID, redirect PC.
REQ-007 SHALL have port BranchTarget, input, 32, the redirect address, valid when Branch=1.
REQ-008 SHALL have port InstrData, input, 32, the instruction memory read data for address PC, combinational.
REQ-009 SHALL have port PC, output, 32, the current fetch address and instruction memory address.
REQ-010 SHALL have port Instruction, output, 32, the IF-stage instruction, equal to InstrData, feeding hazard detection.
REQ-011 SHALL have port InstructionIFID, output, 32, the registered IF/ID instruction.
REQ-012 SHALL have port PCPlus4IFID, output, 32, the registered PC+4 of the IF/ID instruction.
REQ-013 SHALL have port ValidIFID, output, 1; 1 = IF/ID holds a real instruction, 0 = bubble.

Function
REQ-014 SHALL compute PC+4 as 32-bit modulo addition, so 0xFFFFFFFC wraps to 0x00000000 with no error flag.
REQ-015 SHALL define next-PC priority per edge as: Reset gives 0; else PCWrite=0 gives hold; else Branch=1 gives BranchTarget; else PC+4.
REQ-016 SHALL define IF/ID priority per edge as: Reset clears; else PCWrite=0 or IFIDWrite=0 gives hold; else Flush=1 loads a bubble; else loads InstrData, PC+4 and Valid=1.
REQ-017 SHALL hold PC and IF/ID unchanged when PCWrite=0, ignoring Branch and Flush in that cycle, because the branch operands are stale during a load-use stall.
REQ-018 SHALL treat IFIDWrite=0 with PCWrite=1 as a legal input: PC advances or redirects while IF/ID holds, and the fetched word is dropped.
REQ-019 SHALL define a bubble as InstructionIFID=0x00000000 (sll $0,$0,0 NOP), PCPlus4IFID=0 and ValidIFID=0.
REQ-020 SHALL apply Flush and Branch in the same edge, so the wrong-path instruction is squashed as PC loads BranchTarget, costing one bubble cycle.
REQ-021 SHALL load a normal instruction one cycle after its address appears on PC; latency IF to ID = 1 cycle.
REQ-022 SHALL drive Instruction combinationally from InstrData with zero latency.

Reset
REQ-023 SHALL, on the Clk edge with Reset=1, set PC=0x00000000, InstructionIFID=0, PCPlus4IFID=0 and ValidIFID=0.
REQ-024 SHALL give Reset priority over all other inputs, including mid-stall and mid-flush.
REQ-025 SHALL resume fetch at address 0 on the first edge after Reset deasserts.

Configuration
REQ-026 SHALL, when macro IF_ID_PERF_COUNT_EN is defined, add output StallCount (16-bit), which increments on each edge with PCWrite=0.
REQ-027 SHALL, when IF_ID_PERF_COUNT_EN is defined, add output FlushCount (16-bit), which increments on each edge with PCWrite=1 and Flush=1.
REQ-028 SHALL saturate both counters at 0xFFFF and clear them to 0 on Reset.
REQ-029 SHALL, when IF_ID_PERF_COUNT_EN is undefined, omit both counters and their ports entirely, leaving all other behaviour identical.

Verification
REQ-030 SHALL verify sequential fetch: release Reset, with InstrData=0x20080005 at PC 0 -> after edge 1, PC=4, InstructionIFID=0x20080005, PCPlus4IFID=4, ValidIFID=1.
REQ-031 SHALL verify stall: at PC=8, drive PCWrite=0 for 2 cycles -> PC stays 8 and IF/ID stays unchanged; with the macro enabled, StallCount=2.
REQ-032 SHALL verify branch: at PC=0x10, drive Branch=1, Flush=1, BranchTarget=0x40 -> next PC=0x40, InstructionIFID=0, ValidIFID=0; the following edge loads the instruction at 0x40.
REQ-033 SHALL verify stall dominance: drive PCWrite=0, Branch=1, Flush=1, BranchTarget=0x80 -> PC, IF/ID and FlushCount all unchanged.
REQ-034 SHALL verify wrap and reset: at PC=0xFFFFFFFC step once -> PC=0 and PCPlus4IFID=0; then assert Reset during an active Flush -> all outputs return to their reset values.
REQ-035 SHALL verify IFIDWrite hold: drive PCWrite=1, IFIDWrite=0 at PC=0x20 -> PC=0x24 and IF/ID holds its prior contents.
